lsu_byte_master: RTL

- CPU-side load/store initiator for the pipeline MEM stage.
- Accepts one load or store per request, using the codebase's Load/Store size encodings.
- Serialises each request into little-endian byte beats on a byte-wide, acknowledged memory port.
- Assembles and extends load data, stalls the pipeline while busy, and aborts a transfer if no ack arrives within TIMEOUT cycles.

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_load_extend.sv | 27 ++
 rtl/lsu_byte_master.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the byte-serial load/store unit.
//   - Load / Store size encodings used by the pipeline MEM stage
//   - FSM state type for the transfer controller
//   - beat_count(): number of byte beats a request needs
package lsu_pkg;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_BU = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_HU = 3'b011;
  localparam logic [2:0] LD_W  = 3'b100;

  localparam logic [1:0] ST_B = 2'b00;
  localparam logic [1:0] ST_H = 2'b01;
  localparam logic [1:0] ST_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Unlisted encodings fall back to a full word.
  function automatic logic [2:0] beat_count(input logic       is_store,
                                            input logic [2:0] load,
                                            input logic [1:0] store);
    logic [2:0] n;
    n = 3'd4;
    if (is_store) begin
      case (store)
        ST_B:    n = 3'd1;
        ST_H:    n = 3'd2;
        default: n = 3'd4;
      endcase
    end else begin
      case (load)
        LD_B, LD_BU: n = 3'd1;
        LD_H, LD_HU: n = 3'd2;
        default:     n = 3'd4;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational sign/zero extension of an assembled load value.
// Ports:
//   assembled  in  32  little-endian bytes gathered from the memory port
//   load       in  3   load encoding (lb, lbu, lh, lhu, lw; others = lw)
//   data_out   out 32  extended load result
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] assembled,
  input  logic [2:0]  load,
  output logic [31:0] data_out
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    data_out = assembled;
    case (load)
      LD_B:    data_out = {{24{assembled[7]}}, assembled[7:0]};
      LD_BU:   data_out = {24'd0, assembled[7:0]};
      LD_H:    data_out = {{16{assembled[15]}}, assembled[15:0]};
      LD_HU:   data_out = {16'd0, assembled[15:0]};
      default: data_out = assembled;
    endcase
  end

endmodule

// File: rtl/lsu_byte_master.sv
// CPU-side load/store initiator for the MEM stage. Each accepted request is
// split into little-endian byte beats on an acknowledged byte-wide port.
// Loads are assembled and extended; stores report DataOut = 0. A beat that
// sees no ack for TIMEOUT cycles aborts the transfer with a one-cycle err.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid, mRD, mWR   request strobe, load / store (store wins)
//   DAddr, DataIn         byte address, store data
//   Load, Store           size encodings (see lsu_pkg)
//   busy                  high while beats are in flight (pipeline stall)
//   done, err             one-cycle completion / timeout pulses
//   DataOut               load result, held between completions
//   mem_addr, mem_wdata   beat address and write byte
//   mem_re, mem_we        beat read / write request
//   mem_rdata, mem_ack    read byte and beat acknowledge
module lsu_byte_master
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mRD,
  input  logic        mWR,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  input  logic [2:0]  Load,
  input  logic [1:0]  Store,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] DataOut,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  state_t            state_q, state_d;
  logic [31:0]       addr_q;
  logic [31:0]       data_q;
  logic [31:0]       asm_q;
  logic [31:0]       asm_next;
  logic [31:0]       ext_value;
  logic [31:0]       data_out_q;
  logic [2:0]        n_q;
  logic [2:0]        load_q;
  logic [2:0]        idx_q;
  logic              wr_q;
  logic              err_q;
  logic [CNT_W-1:0]  wait_q;

  logic       accept;
  logic       last_beat;
  logic       timeout;
  logic [4:0] lane;

  assign accept    = (state_q == S_IDLE) && req_valid && (mRD || mWR);
  assign last_beat = (idx_q == n_q - 3'd1);
  assign timeout   = (state_q == S_XFER) && !mem_ack &&
                     (wait_q == CNT_W'(TIMEOUT - 1));
  assign lane      = {idx_q[1:0], 3'b000};

  // Assembly including the byte arriving this cycle, so the final beat's
  // data is already extended when the FIN cycle presents DataOut.
  always_comb begin
    asm_next = asm_q;
    asm_next[lane +: 8] = mem_rdata;
  end

  lsu_load_extend u_extend (
    .assembled (asm_next),
    .load      (load_q),
    .data_out  (ext_value)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: registered state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // Next state and beat-port outputs
  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 8'd0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_XFER;
      end
      S_XFER: begin
        busy      = 1'b1;
        mem_addr  = addr_q + 32'(idx_q);  // wraps modulo 2^32
        mem_re    = !wr_q;
        mem_we    = wr_q;
        mem_wdata = wr_q ? data_q[lane +: 8] : 8'd0;
        if (mem_ack && last_beat) state_d = S_FIN;
        else if (timeout)         state_d = S_IDLE;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, beat sequencing, wait counter and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      asm_q      <= 32'd0;
      data_out_q <= 32'd0;
      n_q        <= 3'd0;
      load_q     <= 3'd0;
      idx_q      <= 3'd0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      wait_q     <= '0;
    end else begin
      err_q <= timeout;
      if (accept) begin
        addr_q <= DAddr;
        data_q <= DataIn;
        wr_q   <= mWR;
        load_q <= Load;
        n_q    <= beat_count(mWR, Load, Store);
        idx_q  <= 3'd0;
        wait_q <= '0;
        asm_q  <= 32'd0;
      end else if (state_q == S_XFER) begin
        if (mem_ack) begin
          idx_q  <= idx_q + 3'd1;
          wait_q <= '0;
          asm_q  <= asm_next;
          if (last_beat) data_out_q <= wr_q ? 32'd0 : ext_value;
        end else if (timeout) begin
          wait_q <= '0;
        end else begin
          wait_q <= wait_q + 1'b1;
        end
      end
    end
  end

  assign err     = err_q;
  assign DataOut = data_out_q;

endmodule
